// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM controller.
//   - state_t     : controller FSM states
//   - SRAM_ADDR_W : halfword address width on the board SRAM
//   - SRAM_DATA_W : SRAM data bus width
//   - WORD_W      : pipeline word width
//   - WORD_ADDR_W : word index width (one bit less than the halfword address)
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = 32;
    localparam int WORD_ADDR_W = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Halfword address for one half of a word; the low half sits at the even
    // address (little-endian word layout).
    function automatic logic [SRAM_ADDR_W-1:0] half_addr(
        input logic [WORD_ADDR_W-1:0] word_idx,
        input logic                   upper
    );
        return {word_idx, upper};
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl
// MEM-stage responder that performs one 32-bit word read or write as two
// sequential 16-bit accesses on an asynchronous SRAM, stalling the pipeline
// until the word transfer is complete.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for mem_r_en / mem_w_en; request latched on exit
// LO    | low halfword access at {addr,0}, held WAIT_CYCLES+1 cycles
// HI    | high halfword access at {addr,1}, held WAIT_CYCLES+1 cycles
// DONE  | one cycle; stall released so the pipeline advances
//
// Ports:
//   clk            in     system clock, rising edge
//   rst            in     synchronous active-high reset
//   mem_r_en       in     read request (held while sram_not_ready)
//   mem_w_en       in     write request (wins over read when both set)
//   address        in  17 word index
//   write_data     in  32 word to store
//   read_data      out 32 last word read
//   sram_not_ready out    stall request to the pipeline
//   SRAM_ADDR      out 18 SRAM halfword address
//   SRAM_WE_N      out    SRAM write enable, active low
//   SRAM_DQ        inout 16 SRAM data bus
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [WORD_ADDR_W-1:0] address,
    input  logic [WORD_W-1:0]      write_data,
    output logic [WORD_W-1:0]      read_data,
    output logic                   sram_not_ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

    localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_write_q;
    logic [WORD_ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [SRAM_DATA_W-1:0] rdata_lo_q;
    logic [WORD_W-1:0]      read_data_q;

    logic                   req;
    logic                   phase_last;
    logic                   in_access;
    logic                   drive_bus;
    logic [SRAM_DATA_W-1:0] dq_out;

    assign req        = mem_r_en | mem_w_en;
    assign phase_last = (cnt_q == CNT_LAST);
    assign in_access  = (state_q == LO) || (state_q == HI);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (phase_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_lo_q  <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                op_write_q <= mem_w_en;
                addr_q     <= address;
                wdata_q    <= write_data;
            end
            if (state_q == LO && phase_last && !op_write_q) begin
                rdata_lo_q <= SRAM_DQ;
            end
            // The assembled word lands at the HI->DONE edge, so it is
            // already visible during DONE when the pipeline advances.
            if (state_q == HI && phase_last && !op_write_q) begin
                read_data_q <= {SRAM_DQ, rdata_lo_q};
            end
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        dq_out    = wdata_q[SRAM_DATA_W-1:0];
        if (state_q == LO) begin
            SRAM_ADDR = half_addr(addr_q, 1'b0);
        end else if (state_q == HI) begin
            SRAM_ADDR = half_addr(addr_q, 1'b1);
            dq_out    = wdata_q[WORD_W-1:SRAM_DATA_W];
        end
    end

    // Gating with rst aborts the halfword in flight when reset lands mid-write,
    // so nothing is committed after reset is asserted.
    assign drive_bus      = op_write_q && in_access && !rst;
    assign SRAM_WE_N      = !drive_bus;
    assign SRAM_DQ        = drive_bus ? dq_out : {SRAM_DATA_W{1'bz}};
    assign read_data      = read_data_q;
    assign sram_not_ready = !rst && req && (state_q != DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
// Directed bench for sram_ctrl: one instance with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=0, each attached to its own behavioural 256Kx16 async SRAM.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] address = '0;
    logic [31:0] write_data = '0;
    logic        r_en1 = 1'b0, w_en1 = 1'b0, r_en0 = 1'b0, w_en0 = 1'b0;
    logic        model_oe = 1'b1;

    logic [31:0] rd1, rd0;
    logic        nr1, nr0, we_n1, we_n0;
    logic [17:0] sa1, sa0;
    wire  [15:0] dq1, dq0;

    logic [15:0] mem1 [0:262143];
    logic [15:0] mem0 [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1),
        .address(address), .write_data(write_data), .read_data(rd1),
        .sram_not_ready(nr1), .SRAM_ADDR(sa1), .SRAM_WE_N(we_n1), .SRAM_DQ(dq1)
    );

    sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0),
        .address(address), .write_data(write_data), .read_data(rd0),
        .sram_not_ready(nr0), .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0), .SRAM_DQ(dq0)
    );

    // Behavioural SRAMs: asynchronous read, write while WE_N is low.
    assign dq1 = (model_oe && we_n1) ? mem1[sa1] : 16'bz;
    assign dq0 = (model_oe && we_n0) ? mem0[sa0] : 16'bz;

    always @(posedge clk) begin
        if (pl_en) mem1[pl_addr] <= pl_data;
        else if (!we_n1) mem1[sa1] <= dq1;
    end

    always @(posedge clk) begin
        if (!we_n0) mem0[sa0] <= dq0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic bus_free(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Runs one word operation starting in the current cycle (cycle 0).
    // For reads, d is the word expected back.
    task automatic do_op(input int sel, input bit wr, input bit rd,
                         input logic [16:0] a, input logic [31:0] d, input int t);
        address    = a;
        write_data = d;
        model_oe   = !wr;
        if (sel == 1) begin w_en1 = wr; r_en1 = rd; end
        else          begin w_en0 = wr; r_en0 = rd; end
        if (!wr) sb_q.push_back(d);
        for (int c = 0; c <= 2 * t + 1; c++) begin
            logic        nr, wen;
            logic [17:0] sa;
            logic [15:0] dq;
            logic [31:0] rdv;
            @(negedge clk);
            nr  = (sel == 1) ? nr1 : nr0;
            wen = (sel == 1) ? we_n1 : we_n0;
            sa  = (sel == 1) ? sa1 : sa0;
            dq  = (sel == 1) ? dq1 : dq0;
            rdv = (sel == 1) ? rd1 : rd0;
            check("not_ready", 32'(nr), 32'(c <= 2 * t));
            if (c >= 1 && c <= t) begin
                check("addr_lo", 32'(sa), 32'({a, 1'b0}));
                check("we_n_lo", 32'(wen), 32'(!wr));
                if (wr) check("dq_lo", 32'(dq), 32'(d[15:0]));
            end else if (c > t && c <= 2 * t) begin
                check("addr_hi", 32'(sa), 32'({a, 1'b1}));
                check("we_n_hi", 32'(wen), 32'(!wr));
                if (wr) check("dq_hi", 32'(dq), 32'(d[31:16]));
            end else begin
                check("we_n_idle", 32'(wen), 32'd1);
            end
            if (c == 2 * t + 1) begin
                if (wr) begin
                    check("dq_free_done", 32'(bus_free(dq)), 32'd1);
                    check("rdata_kept", rdv, last_rd[sel]);
                end else if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check("read_data", rdv, e);
                    last_rd[sel] = e;
                end
            end
        end
        @(posedge clk);
        #1;
        w_en1 = 1'b0; r_en1 = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset, with a request present: the stall must stay low.
        r_en1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_nr_forced", 32'(nr1), 32'd0);
        check("rst_we_n", 32'(we_n1), 32'd1);
        check("rst_addr", 32'(sa1), 32'd0);
        check("rst_rdata", rd1, 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        r_en1 = 1'b0;
        @(posedge clk); #1;

        // 1: write 0xDEADBEEF to word 0x10
        do_op(1, 1'b1, 1'b0, 17'h00010, 32'hDEADBEEF, 2);
        check("t1_mem_lo", 32'(mem1[18'h00020]), 32'h0000BEEF);
        check("t1_mem_hi", 32'(mem1[18'h00021]), 32'h0000DEAD);

        // 2: read it back
        do_op(1, 1'b0, 1'b1, 17'h00010, 32'hDEADBEEF, 2);

        // 3: both enables high -> write
        do_op(1, 1'b1, 1'b1, 17'h00004, 32'h12345678, 2);
        check("t3_mem_lo", 32'(mem1[18'h00008]), 32'h00005678);
        check("t3_mem_hi", 32'(mem1[18'h00009]), 32'h00001234);
        check("t3_rdata", rd1, 32'hDEADBEEF);

        // 4: reset in the first HI cycle of a write
        preload(18'h00040, 16'h0000);
        preload(18'h00041, 16'hAAAA);
        model_oe   = 1'b0;
        address    = 17'h00020;
        write_data = 32'hCAFEF00D;
        w_en1      = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            check("t4_nr", 32'(nr1), 32'd1);
            if (c >= 1) check("t4_dq_lo", 32'(dq1), 32'h0000F00D);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t4_nr_rst", 32'(nr1), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        w_en1 = 1'b0;
        @(negedge clk);
        check("t4_state", 32'(u_dut1.state_q), 32'(IDLE));
        check("t4_cnt", 32'(u_dut1.cnt_q), 32'd0);
        check("t4_we_n", 32'(we_n1), 32'd1);
        check("t4_addr", 32'(sa1), 32'd0);
        check("t4_dq_free", 32'(bus_free(dq1)), 32'd1);
        check("t4_rdata", rd1, 32'd0);
        last_rd[1] = '0;
        check("t4_mem_lo", 32'(mem1[18'h00040]), 32'h0000F00D);
        check("t4_mem_hi", 32'(mem1[18'h00041]), 32'h0000AAAA);
        @(posedge clk); #1;

        // 5: back-to-back reads at the top and bottom of the address space
        preload(18'h3FFFE, 16'h1111);
        preload(18'h3FFFF, 16'h2222);
        preload(18'h00000, 16'h3333);
        preload(18'h00001, 16'h4444);
        do_op(1, 1'b0, 1'b1, 17'h1FFFF, 32'h22221111, 2);
        do_op(1, 1'b0, 1'b1, 17'h00000, 32'h44443333, 2);

        // 6: zero wait cycles
        do_op(0, 1'b1, 1'b0, 17'h00155, 32'h0BADCAFE, 1);
        check("t6_mem_lo", 32'(mem0[18'h002AA]), 32'h0000CAFE);
        check("t6_mem_hi", 32'(mem0[18'h002AB]), 32'h00000BAD);
        do_op(0, 1'b0, 1'b1, 17'h00155, 32'h0BADCAFE, 1);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
